// File: rtl/bpm_step_controller.sv
// Debounced four-button BPM stepper with arbitration and range-guarded shadow BPM.
// Hold-to-repeat is built only when BPM_AUTO_REPEAT_EN is defined.
module bpm_step_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int BPM_MIN         = 30,
    parameter int BPM_MAX         = 300,
    parameter int BPM_RESET       = 120
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_btn_raw,
    output logic       o_btn_plus_1,
    output logic       o_btn_plus_5,
    output logic       o_btn_minus_1,
    output logic       o_btn_minus_5,
    output logic [8:0] o_bpm,
    output logic       o_limit
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic signed [9:0] BPM_MIN_S = 10'(BPM_MIN);
    localparam logic signed [9:0] BPM_MAX_S = 10'(BPM_MAX);

`ifdef BPM_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRE,
        ST_RELEASE
`ifdef BPM_AUTO_REPEAT_EN
        ,
        ST_HOLD,
        ST_REPEAT
`endif
    } state_e;

    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [3:0]    deb_q;
    logic [3:0]    deb_prev_q;
    logic [3:0]    press_q;
    logic [DW-1:0] db_cnt_q [4];

    state_e        state_q;
    logic [1:0]    owner_q;
    logic [8:0]    bpm_q;
    logic [3:0]    pulse_q;
    logic          limit_q;
`ifdef BPM_AUTO_REPEAT_EN
    logic [RW-1:0] rpt_q;
`endif

    logic [1:0]        step_sel;
    logic signed [9:0] step_delta;
    logic signed [9:0] cand;
    logic              in_range;
    logic              owned_held;
    logic              attempt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Counter only advances while synced and debounced levels disagree.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            deb_q <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    deb_q[i]    <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            deb_prev_q <= '0;
            press_q    <= '0;
        end else begin
            deb_prev_q <= deb_q;
            press_q    <= deb_q & ~deb_prev_q;
        end
    end

    always_comb begin
        step_sel = owner_q;
        if (state_q == ST_IDLE) begin
            if (press_q[0]) begin
                step_sel = 2'd0;
            end else if (press_q[1]) begin
                step_sel = 2'd1;
            end else if (press_q[2]) begin
                step_sel = 2'd2;
            end else if (press_q[3]) begin
                step_sel = 2'd3;
            end
        end
    end

    always_comb begin
        step_delta = 10'sd1;
        unique case (step_sel)
            2'd0: step_delta = 10'sd1;
            2'd1: step_delta = 10'sd5;
            2'd2: step_delta = -10'sd1;
            2'd3: step_delta = -10'sd5;
        endcase
    end

    assign cand       = $signed({1'b0, bpm_q}) + step_delta;
    assign in_range   = (cand >= BPM_MIN_S) && (cand <= BPM_MAX_S);
    assign owned_held = deb_q[owner_q];

    // Release has precedence over a repeat falling due in the same cycle.
    always_comb begin
        attempt = 1'b0;
        unique case (state_q)
            ST_IDLE:    attempt = |press_q;
`ifdef BPM_AUTO_REPEAT_EN
            ST_HOLD:    attempt = owned_held && (rpt_q == RD_LAST);
            ST_REPEAT:  attempt = owned_held && (rpt_q == RP_LAST);
`endif
            default:    attempt = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            bpm_q   <= 9'(BPM_RESET);
            pulse_q <= '0;
            limit_q <= 1'b0;
`ifdef BPM_AUTO_REPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            pulse_q <= '0;
            limit_q <= 1'b0;
            if (attempt) begin
                if (in_range) begin
                    pulse_q[step_sel] <= 1'b1;
                    bpm_q             <= cand[8:0];
                end else begin
                    limit_q <= 1'b1;
                end
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (|press_q) begin
                        owner_q <= step_sel;
                        state_q <= ST_FIRE;
`ifdef BPM_AUTO_REPEAT_EN
                        rpt_q   <= '0;
`endif
                    end
                end
                ST_FIRE: begin
`ifdef BPM_AUTO_REPEAT_EN
                    rpt_q   <= rpt_q + 1'b1;
                    state_q <= ST_HOLD;
`else
                    state_q <= ST_RELEASE;
`endif
                end
`ifdef BPM_AUTO_REPEAT_EN
                ST_HOLD: begin
                    if (!owned_held) begin
                        state_q <= ST_RELEASE;
                    end else if (rpt_q == RD_LAST) begin
                        rpt_q   <= '0;
                        state_q <= ST_REPEAT;
                    end else begin
                        rpt_q <= rpt_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!owned_held) begin
                        state_q <= ST_RELEASE;
                    end else if (rpt_q == RP_LAST) begin
                        rpt_q <= '0;
                    end else begin
                        rpt_q <= rpt_q + 1'b1;
                    end
                end
`endif
                ST_RELEASE: begin
                    if (deb_q == 4'b0000) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_btn_plus_1  = pulse_q[0];
    assign o_btn_plus_5  = pulse_q[1];
    assign o_btn_minus_1 = pulse_q[2];
    assign o_btn_minus_5 = pulse_q[3];
    assign o_bpm         = bpm_q;
    assign o_limit       = limit_q;

endmodule
